// File: rtl/sift_pkg.sv
// Shared types for the SIFT gradient pipeline.
// Holds the gradient_fetch FSM state enum, the eight orientation-octant codes,
// and the result record layout {addr, mag, bin}. The record is sized for the
// default 64x64 image at 8-bit depth.
package sift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } grad_state_t;

  // Orientation octants, counterclockwise from +x.
  localparam logic [2:0] BIN_0 = 3'd0;
  localparam logic [2:0] BIN_1 = 3'd1;
  localparam logic [2:0] BIN_2 = 3'd2;
  localparam logic [2:0] BIN_3 = 3'd3;
  localparam logic [2:0] BIN_4 = 3'd4;
  localparam logic [2:0] BIN_5 = 3'd5;
  localparam logic [2:0] BIN_6 = 3'd6;
  localparam logic [2:0] BIN_7 = 3'd7;

  localparam int unsigned GRAD_ADDR_W = 12;
  localparam int unsigned GRAD_MAG_W  = 10;
  localparam int unsigned GRAD_BIN_W  = 3;

  typedef struct packed {
    logic [GRAD_ADDR_W-1:0] addr;
    logic [GRAD_MAG_W-1:0]  mag;
    logic [GRAD_BIN_W-1:0]  bin;
  } gradient_result_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst_n (async active-low), push/din (write), pop (read ack),
// rd_data_c (head entry, combinational from storage), not_empty_c (head valid),
// count (registered occupancy, used by the upstream credit logic).
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [DATA_W-1:0]                din,
  input  logic                             pop,
  output logic [DATA_W-1:0]                rd_data_c,
  output logic                             not_empty_c,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign not_empty_c = (count != '0);
  assign rd_data_c   = mem[rd_ptr];
  assign do_pop      = pop && not_empty_c;
  // A full FIFO may still accept a write in the same cycle it is popped.
  assign do_push     = push && ((count < CNT_W'(DEPTH)) || do_pop);

  // Storage and pointers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= PTR_W'(wr_ptr + PTR_W'(1));
      end
      if (do_pop) rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      case ({do_push, do_pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gradient_fetch.sv
// Raster-order reader of the x/y gradient BRAMs. Each (gx, gy) pair becomes a
// magnitude |gx|+|gy| and an 8-way orientation octant, emitted on a
// valid/ready stream through a credit-protected FWFT skid FIFO.
// Ports:
//   clk_in, rst_in (async active-low), start_in (one-cycle start, IDLE only)
//   read_addr / read_addr_valid : shared BRAM address and read enable
//   x_pixel_in / y_pixel_in      : signed gradients, 2 cycles after the read
//   out_valid / out_ready        : result handshake
//   out_addr / out_mag / out_bin : result payload
//   busy (not IDLE), fetch_done (one-cycle pulse after last accept)
// Build option: define GRAD_MAG_SAT_EN to saturate out_mag at 2^BIT_DEPTH-1.
module gradient_fetch
  import sift_pkg::*;
#(
  parameter int unsigned BIT_DEPTH  = 8,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned HEIGHT     = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ADDR_W    = $clog2(WIDTH * HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic [ADDR_W-1:0]    read_addr,
  output logic                 read_addr_valid,
  input  logic [BIT_DEPTH:0]   x_pixel_in,
  input  logic [BIT_DEPTH:0]   y_pixel_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [BIT_DEPTH+1:0] out_mag,
  output logic [2:0]           out_bin,
  output logic                 busy,
  output logic                 fetch_done
);

  localparam int unsigned GW     = BIT_DEPTH + 1;
  localparam int unsigned MAG_W  = BIT_DEPTH + 2;
  localparam int unsigned BIN_W  = 3;
  localparam int unsigned NPIX   = WIDTH * HEIGHT;
  localparam int unsigned DATA_W = ADDR_W + MAG_W + BIN_W;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CR_W   = $clog2(FIFO_DEPTH + 4) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  grad_state_t state;
  grad_state_t state_next;

  logic              issue_c;
  logic              pop_c;
  logic              credit_ok_c;
  logic [CR_W-1:0]   credit_used_c;
  logic [FCNT_W-1:0] fifo_count;

  logic              s1_valid, s2_valid, comp_valid;
  logic [ADDR_W-1:0] s1_addr, s2_addr, comp_addr;
  logic [MAG_W-1:0]  comp_mag;
  logic [BIN_W-1:0]  comp_bin;

  logic [GW-1:0]     ax_c, ay_c;
  logic [MAG_W-1:0]  sum_c, mag_c;
  logic [BIN_W-1:0]  bin_c;
  logic              gx_neg, gy_neg, gx_zero, gy_zero;

  assign pop_c = out_valid && out_ready;

  // Credit: results already queued (net of this cycle's pop) plus reads still
  // in the BRAM stages or the compute register must leave room for one more.
  assign credit_used_c = CR_W'(fifo_count) - CR_W'(pop_c) + CR_W'(s1_valid)
                       + CR_W'(s2_valid) + CR_W'(comp_valid);
  assign credit_ok_c   = credit_used_c < CR_W'(FIFO_DEPTH);

  assign read_addr_valid = issue_c;

  // Next-state and read-issue decode.
  always_comb begin
    state_next = state;
    issue_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_in) state_next = ST_READ;
      end
      ST_READ: begin
        if (credit_ok_c) begin
          issue_c = 1'b1;
          if (read_addr == LAST_ADDR) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid && !s2_valid && !comp_valid &&
            ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && pop_c)))
          state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register with registered status outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != ST_IDLE);
      fetch_done <= (state_next == ST_DONE);
    end
  end

  // Raster address counter; parks on the last address once it has been read.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      read_addr <= '0;
    end else if ((state == ST_IDLE) && start_in) begin
      read_addr <= '0;
    end else if (issue_c && (read_addr != LAST_ADDR)) begin
      read_addr <= ADDR_W'(read_addr + ADDR_W'(1));
    end
  end

  // Magnitude and octant of the pair arriving from the BRAMs this cycle.
  always_comb begin
    gx_neg  = x_pixel_in[GW-1];
    gy_neg  = y_pixel_in[GW-1];
    gx_zero = (x_pixel_in == '0);
    gy_zero = (y_pixel_in == '0);
    // Unsigned GW-bit absolute value, so the most negative code maps to 2^BIT_DEPTH.
    ax_c    = gx_neg ? GW'(~x_pixel_in + GW'(1)) : x_pixel_in;
    ay_c    = gy_neg ? GW'(~y_pixel_in + GW'(1)) : y_pixel_in;
    sum_c   = MAG_W'(ax_c) + MAG_W'(ay_c);
`ifdef GRAD_MAG_SAT_EN
    mag_c   = (sum_c > MAG_W'((1 << BIT_DEPTH) - 1)) ? MAG_W'((1 << BIT_DEPTH) - 1) : sum_c;
`else
    mag_c   = sum_c;
`endif
    // Octant boundaries fall into the higher bin; the zero vector is bin 0.
    if (!gx_neg && !gx_zero && !gy_neg)
      bin_c = (ay_c >= ax_c) ? BIN_1 : BIN_0;
    else if ((gx_neg || gx_zero) && !gy_neg && !gy_zero)
      bin_c = (ax_c >= ay_c) ? BIN_3 : BIN_2;
    else if (gx_neg && (gy_neg || gy_zero))
      bin_c = (ay_c >= ax_c) ? BIN_5 : BIN_4;
    else if (!gx_neg && gy_neg)
      bin_c = (ax_c >= ay_c) ? BIN_7 : BIN_6;
    else
      bin_c = BIN_0;
  end

  // Address/valid delay line matching the BRAM latency, then the compute register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      comp_valid <= 1'b0;
      s1_addr    <= '0;
      s2_addr    <= '0;
      comp_addr  <= '0;
      comp_mag   <= '0;
      comp_bin   <= '0;
    end else begin
      s1_valid   <= issue_c;
      s1_addr    <= read_addr;
      s2_valid   <= s1_valid;
      s2_addr    <= s1_addr;
      comp_valid <= s2_valid;
      if (s2_valid) begin
        comp_addr <= s2_addr;
        comp_mag  <= mag_c;
        comp_bin  <= bin_c;
      end
    end
  end

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_result_fifo (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .push        (comp_valid),
    .din         ({comp_addr, comp_mag, comp_bin}),
    .pop         (pop_c),
    .rd_data_c   ({out_addr, out_mag, out_bin}),
    .not_empty_c (out_valid),
    .count       (fifo_count)
  );

endmodule

// File: tb/tb_gradient_fetch.sv
// Directed bench for gradient_fetch on a 4x4 image with a 2-cycle BRAM model.
module tb_gradient_fetch;
  import sift_pkg::*;

  localparam int unsigned BD   = 8;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned FD   = 4;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned AW   = 4;
  localparam int unsigned GW   = BD + 1;
`ifdef GRAD_MAG_SAT_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [AW-1:0] read_addr;
  logic          read_addr_valid;
  logic [GW-1:0] x_pixel_in, y_pixel_in;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [BD+1:0] out_mag;
  logic [2:0]    out_bin;
  logic          busy;
  logic          fetch_done;

  always #5 clk = ~clk;

  gradient_fetch #(.BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(FD)) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .read_addr(read_addr), .read_addr_valid(read_addr_valid),
    .x_pixel_in(x_pixel_in), .y_pixel_in(y_pixel_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_mag(out_mag), .out_bin(out_bin),
    .busy(busy), .fetch_done(fetch_done)
  );

  // Gradient BRAM model: data valid two cycles after the address is presented.
  logic [GW-1:0] gx_mem [NPIX];
  logic [GW-1:0] gy_mem [NPIX];
  logic [AW-1:0] p1_addr;
  logic [GW-1:0] p2_x, p2_y;
  always @(posedge clk) begin
    p1_addr <= read_addr;
    p2_x    <= gx_mem[p1_addr];
    p2_y    <= gy_mem[p1_addr];
  end
  assign x_pixel_in = p2_x;
  assign y_pixel_in = p2_y;

  int exp_mag [NPIX];
  int exp_bin [NPIX];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor state
  gradient_result_t res_q[$];
  gradient_result_t mon_r, prev_r;
  logic mon_clr = 1'b0;
  logic prev_stall;
  int cyc = 0, start_cyc, done_cyc, first_cyc, done_count;
  int issued, accepted, max_out, hold_err;

  initial forever begin
    @(negedge clk);
    cyc++;
    mon_r.addr = GRAD_ADDR_W'(out_addr);
    mon_r.mag  = GRAD_MAG_W'(out_mag);
    mon_r.bin  = out_bin;
    if (mon_clr || !rst_in) begin
      res_q.delete();
      issued = 0; accepted = 0; max_out = 0; hold_err = 0;
      done_count = 0; done_cyc = -1; first_cyc = -1; start_cyc = -1;
      prev_stall = 1'b0;
    end else begin
      if (start_in && !busy && start_cyc < 0) start_cyc = cyc;
      if (read_addr_valid) issued++;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (prev_stall && (!out_valid || mon_r != prev_r)) hold_err++;
      if (out_valid && out_ready) begin
        res_q.push_back(mon_r);
        accepted++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (fetch_done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = mon_r;
    end
  end

  task automatic load(input int i, input int gx, input int gy, input int mag, input int bin);
    gx_mem[i]  = GW'(gx);
    gy_mem[i]  = GW'(gy);
    exp_mag[i] = mag;
    exp_bin[i] = bin;
  endtask

  task automatic run_scan(input bit rand_ready, input int restart_at, input int reset_after);
    bit finished;
    finished = 1'b0;
    @(posedge clk); #1; mon_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk); #1; mon_clr = 1'b0;
    @(posedge clk); #1;
    start_in  = 1'b1;
    out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    for (int k = 0; k < 3000 && !finished; k++) begin
      @(posedge clk); #1;
      start_in  = (k == restart_at);
      out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (reset_after > 0 && accepted >= reset_after) begin
        rst_in   = 1'b0;
        start_in = 1'b0;
        finished = 1'b1;
      end else if (done_count > 0) begin
        start_in = 1'b0;
        repeat (6) begin @(posedge clk); #1; out_ready = 1'b1; end
        finished = 1'b1;
      end
    end
    check_eq("scan_timeout", int'(!finished), 0);
  endtask

  task automatic check_scan(input string tag);
    check_eq({tag, "_count"}, res_q.size(), NPIX);
    for (int i = 0; i < res_q.size() && i < NPIX; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), int'(res_q[i].addr), i);
      check_eq($sformatf("%s_mag%0d", tag, i), int'(res_q[i].mag), exp_mag[i]);
      check_eq($sformatf("%s_bin%0d", tag, i), int'(res_q[i].bin), exp_bin[i]);
    end
    check_eq({tag, "_done_pulses"}, done_count, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_read_addr"}, int'(read_addr), 0);
    check_eq({tag, "_read_addr_valid"}, int'(read_addr_valid), 0);
    check_eq({tag, "_out_valid"}, int'(out_valid), 0);
    check_eq({tag, "_out_addr"}, int'(out_addr), 0);
    check_eq({tag, "_out_mag"}, int'(out_mag), 0);
    check_eq({tag, "_out_bin"}, int'(out_bin), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_fetch_done"}, int'(fetch_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in    = 1'b0;
    start_in  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) load(i, 1, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_in = 1'b1;

    // Basic scan: gx=1, gy=0 everywhere, downstream always ready.
    run_scan(1'b0, -1, 0);
    check_scan("basic");
    check_eq("basic_first_valid_lat", first_cyc - start_cyc, 5);
    check_eq("basic_done_lat", done_cyc - start_cyc, int'(NPIX) + 5);
    check_eq("basic_max_inflight", max_out, 4);
    check_eq("basic_busy_after", int'(busy), 0);

    // Octant sweep and extremes.
    load(0,     5,    5, 10, 1);
    load(1,     0,    7,  7, 2);
    load(2,    -3,    3,  6, 3);
    load(3,    -4,    0,  4, 4);
    load(4,     0,   -2,  2, 6);
    load(5,     2,   -2,  4, 7);
    load(6,     0,    0,  0, 0);
    load(7,  -256, -256, SAT ? 255 : 512, 5);
    load(8,    -1,   -7,  8, 5);
    load(9,     7,    1,  8, 0);
    load(10,  255, -256, SAT ? 255 : 511, 6);
    load(11,   -2,    5,  7, 2);
    run_scan(1'b0, -1, 0);
    check_scan("octant");

    // Random backpressure at 30% ready duty.
    run_scan(1'b1, -1, 0);
    check_scan("bp");
    check_eq("bp_inflight_le_depth", int'(max_out <= int'(FD)), 1);
    check_eq("bp_hold_errors", hold_err, 0);

    // Second start pulse mid-scan must be ignored.
    run_scan(1'b0, 6, 0);
    check_scan("restart");

    // Reset after ten accepted results, then a fresh scan.
    run_scan(1'b0, -1, 10);
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b1;
    run_scan(1'b0, -1, 0);
    check_scan("rescan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
